// File: rtl/snn_output_spike_counter_if.sv
// Control, strobe and readback bundle between the SNN output spike counter
// and its sequencer / config-register block.
interface snn_output_spike_counter_if #(
  parameter int NUM_OUTPUTS = 2,
  parameter int COUNT_WIDTH = 9,
  parameter int IDX_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
);
  logic                   clear;
  logic                   spikes_valid;
  logic [NUM_OUTPUTS-1:0] spikes;
  logic                   last;
  logic [IDX_WIDTH-1:0]   count_sel;
  logic [COUNT_WIDTH-1:0] count_rdata;
  logic [IDX_WIDTH-1:0]   winner;
  logic [COUNT_WIDTH-1:0] winner_count;
  logic                   winner_valid;
  logic                   no_spikes;
  logic                   busy;

  modport master (
    output clear, spikes_valid, spikes, last, count_sel,
    input  count_rdata, winner, winner_count, winner_valid, no_spikes, busy
  );

  modport slave (
    input  clear, spikes_valid, spikes, last, count_sel,
    output count_rdata, winner, winner_count, winner_valid, no_spikes, busy
  );
endinterface

// File: rtl/snn_output_spike_counter.sv
// Per-neuron output spike counters for one SNN run, followed by a sequential
// argmax (lowest index wins ties) that yields the classification winner.
//
//  state    | meaning
//  S_IDLE   | after reset, strobes ignored until clear
//  S_COUNT  | accumulating saturating spike counts
//  S_ARGMAX | scanning one neuron per cycle, then latching the winner
//  S_DONE   | winner held, strobes ignored until clear
module snn_output_spike_counter #(
  parameter int NUM_OUTPUTS = 2,
  parameter int COUNT_WIDTH = 9,
  parameter int IDX_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input logic clk,
  input logic rst,
  snn_output_spike_counter_if.slave bus
);
  localparam int SCAN_WIDTH = $clog2(NUM_OUTPUTS + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_ARGMAX, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_OUTPUTS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_OUTPUTS];
  logic [SCAN_WIDTH-1:0]  scan_q, scan_d;
  logic [IDX_WIDTH-1:0]   best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
  logic [COUNT_WIDTH-1:0] count_rdata_q, count_rdata_d;
  logic [IDX_WIDTH-1:0]   winner_q, winner_d;
  logic [COUNT_WIDTH-1:0] winner_count_q, winner_count_d;
  logic                   winner_valid_q, winner_valid_d;
  logic                   no_spikes_q, no_spikes_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] scan_cnt;

  // Both muxes go through a compare loop so out-of-range selects read 0.
  always_comb begin
    scan_cnt      = '0;
    count_rdata_d = '0;
    for (int n = 0; n < NUM_OUTPUTS; n++) begin
      if (int'(scan_q) == n) scan_cnt = cnt_q[n];
      if (int'(bus.count_sel) == n) count_rdata_d = cnt_q[n];
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    scan_d         = scan_q;
    best_idx_d     = best_idx_q;
    best_cnt_d     = best_cnt_q;
    winner_d       = winner_q;
    winner_count_d = winner_count_q;
    winner_valid_d = winner_valid_q;
    no_spikes_d    = no_spikes_q;
    busy_d         = busy_q;

    case (state_q)
      S_COUNT: begin
        if (bus.spikes_valid) begin
          for (int n = 0; n < NUM_OUTPUTS; n++) begin
            if (bus.spikes[n] && cnt_q[n] != CNT_MAX) cnt_d[n] = cnt_q[n] + 1'b1;
          end
          if (bus.last) begin
            state_d = S_ARGMAX;
            scan_d  = '0;
          end
        end
      end
      S_ARGMAX: begin
        // One extra cycle past the last index to latch the result.
        if (scan_q == SCAN_WIDTH'(NUM_OUTPUTS)) begin
          winner_d       = best_idx_q;
          winner_count_d = best_cnt_q;
          no_spikes_d    = (best_cnt_q == '0);
          winner_valid_d = 1'b1;
          busy_d         = 1'b0;
          state_d        = S_DONE;
        end else begin
          if (scan_q == '0 || scan_cnt > best_cnt_q) begin
            best_idx_d = IDX_WIDTH'(scan_q);
            best_cnt_d = scan_cnt;
          end
          scan_d = scan_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (bus.clear) begin
      for (int n = 0; n < NUM_OUTPUTS; n++) cnt_d[n] = '0;
      winner_valid_d = 1'b0;
      no_spikes_d    = 1'b0;
      busy_d         = 1'b1;
      state_d        = S_COUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      for (int n = 0; n < NUM_OUTPUTS; n++) cnt_q[n] <= '0;
      scan_q         <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      count_rdata_q  <= '0;
      winner_q       <= '0;
      winner_count_q <= '0;
      winner_valid_q <= 1'b0;
      no_spikes_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      scan_q         <= scan_d;
      best_idx_q     <= best_idx_d;
      best_cnt_q     <= best_cnt_d;
      count_rdata_q  <= count_rdata_d;
      winner_q       <= winner_d;
      winner_count_q <= winner_count_d;
      winner_valid_q <= winner_valid_d;
      no_spikes_q    <= no_spikes_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.count_rdata  = count_rdata_q;
  assign bus.winner       = winner_q;
  assign bus.winner_count = winner_count_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.no_spikes    = no_spikes_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_snn_output_spike_counter.sv
// Randomized bench for snn_output_spike_counter (3 neurons, 4-bit counters)
// against a run-level reference model of counts and winner.
module tb_snn_output_spike_counter;
  localparam int N    = 3;
  localparam int CW   = 4;
  localparam int IW   = 2;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int exp_cnt [N];
  bit mdl_counting = 1'b0;

  snn_output_spike_counter_if #(.NUM_OUTPUTS(N), .COUNT_WIDTH(CW), .IDX_WIDTH(IW)) bus ();

  snn_output_spike_counter #(.NUM_OUTPUTS(N), .COUNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset();
    for (int n = 0; n < N; n++) exp_cnt[n] = 0;
    mdl_counting = 1'b0;
  endtask

  function automatic int mdl_winner();
    int w = 0;
    for (int n = 1; n < N; n++) if (exp_cnt[n] > exp_cnt[w]) w = n;
    return w;
  endfunction

  task automatic do_clear(input bit with_spikes);
    bus.clear        = 1'b1;
    bus.spikes_valid = with_spikes;
    bus.spikes       = N'($urandom);
    bus.last         = 1'($urandom);
    tick();
    bus.clear        = 1'b0;
    bus.spikes_valid = 1'b0;
    bus.last         = 1'b0;
    for (int n = 0; n < N; n++) exp_cnt[n] = 0;
    mdl_counting = 1'b1;
  endtask

  task automatic strobe(input logic [N-1:0] spk, input bit lst);
    bus.spikes_valid = 1'b1;
    bus.spikes       = spk;
    bus.last         = lst;
    tick();
    bus.spikes_valid = 1'b0;
    bus.last         = 1'b0;
    if (mdl_counting) begin
      for (int n = 0; n < N; n++) if (spk[n]) exp_cnt[n] = (exp_cnt[n] < CMAX) ? exp_cnt[n] + 1 : CMAX;
      if (lst) mdl_counting = 1'b0;
    end
  endtask

  task automatic wait_winner(output int cyc);
    cyc = 0;
    while (bus.winner_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic read_count(input int sel, output logic [CW-1:0] val);
    bus.count_sel = IW'(sel);
    tick();
    val = bus.count_rdata;
  endtask

  task automatic test_reset();
    logic [CW-1:0] v;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.winner_valid !== 1'b0) begin failures++; $display("FAIL reset_winner_valid: got %0b expected 0", bus.winner_valid); end
    checks++; if (bus.no_spikes !== 1'b0) begin failures++; $display("FAIL reset_no_spikes: got %0b expected 0", bus.no_spikes); end
    checks++; if (bus.winner !== '0 || bus.winner_count !== '0) begin failures++; $display("FAIL reset_winner: got %0d/%0d expected 0/0", bus.winner, bus.winner_count); end
    checks++; if (bus.count_rdata !== '0) begin failures++; $display("FAIL reset_count_rdata: got %0d expected 0", bus.count_rdata); end
    rst = 1'b0;
    tick();
    repeat (3) strobe(3'b111, 1'b0);
    strobe(3'b111, 1'b1);
    for (int s = 0; s < N; s++) begin
      read_count(s, v);
      checks++; if (v !== '0) begin failures++; $display("FAIL idle_ignored sel=%0d: got %0d expected 0", s, v); end
    end
    checks++; if (bus.busy !== 1'b0 || bus.winner_valid !== 1'b0) begin failures++; $display("FAIL idle_state: busy=%0b winner_valid=%0b expected 0/0", bus.busy, bus.winner_valid); end
  endtask

  task automatic test_basic();
    logic [N-1:0] vec [14];
    logic [N-1:0] tmp;
    logic [CW-1:0] v;
    int j, cyc;
    for (int i = 0; i < 14; i++) vec[i] = (i < 10) ? 3'b010 : 3'b001;
    for (int i = 13; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = vec[i]; vec[i] = vec[j]; vec[j] = tmp;
    end
    do_clear(1'b0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_clear: got %0b expected 1", bus.busy); end
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(3, 0) == 0) tick();
      strobe(vec[i], i == 13);
    end
    wait_winner(cyc);
    checks++; if (cyc != N + 1) begin failures++; $display("FAIL basic_latency: got %0d cycles expected %0d", cyc, N + 1); end
    checks++; if (bus.winner !== 2'd1) begin failures++; $display("FAIL basic_winner: got %0d expected 1", bus.winner); end
    checks++; if (bus.winner_count !== 4'd10) begin failures++; $display("FAIL basic_winner_count: got %0d expected 10", bus.winner_count); end
    checks++; if (bus.no_spikes !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL basic_flags: no_spikes=%0b busy=%0b expected 0/0", bus.no_spikes, bus.busy); end
    read_count(0, v);
    checks++; if (v !== 4'd4) begin failures++; $display("FAIL basic_count0: got %0d expected 4", v); end
    read_count(1, v);
    checks++; if (v !== 4'd10) begin failures++; $display("FAIL basic_count1: got %0d expected 10", v); end
  endtask

  task automatic test_tie();
    logic [CW-1:0] v;
    int cyc;
    do_clear(1'b0);
    for (int i = 0; i < 5; i++) strobe(3'b110, i == 4);
    wait_winner(cyc);
    checks++; if (bus.winner !== 2'd1 || bus.winner_count !== 4'd5) begin failures++; $display("FAIL tie_winner: got %0d/%0d expected 1/5", bus.winner, bus.winner_count); end
    checks++; if (bus.no_spikes !== 1'b0) begin failures++; $display("FAIL tie_no_spikes: got %0b expected 0", bus.no_spikes); end
    repeat (4) strobe(3'b111, 1'b1);
    for (int s = 0; s < N; s++) begin
      read_count(s, v);
      checks++; if (v !== CW'(exp_cnt[s])) begin failures++; $display("FAIL done_ignored sel=%0d: got %0d expected %0d", s, v, exp_cnt[s]); end
    end
    checks++; if (bus.winner_valid !== 1'b1 || bus.winner !== 2'd1) begin failures++; $display("FAIL done_hold: valid=%0b winner=%0d expected 1/1", bus.winner_valid, bus.winner); end
  endtask

  task automatic test_no_spikes();
    int cyc;
    do_clear(1'b0);
    for (int i = 0; i < 256; i++) strobe('0, i == 255);
    wait_winner(cyc);
    checks++; if (cyc != N + 1) begin failures++; $display("FAIL nospk_latency: got %0d expected %0d", cyc, N + 1); end
    checks++; if (bus.winner !== '0 || bus.winner_count !== '0) begin failures++; $display("FAIL nospk_winner: got %0d/%0d expected 0/0", bus.winner, bus.winner_count); end
    checks++; if (bus.no_spikes !== 1'b1) begin failures++; $display("FAIL nospk_flag: got %0b expected 1", bus.no_spikes); end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] v;
    int cyc;
    do_clear(1'b0);
    for (int i = 0; i < 20; i++) strobe(3'b111, i == 19);
    wait_winner(cyc);
    checks++; if (bus.winner !== '0 || bus.winner_count !== 4'd15) begin failures++; $display("FAIL sat_winner: got %0d/%0d expected 0/15", bus.winner, bus.winner_count); end
    for (int s = 0; s < N; s++) begin
      read_count(s, v);
      checks++; if (v !== 4'd15) begin failures++; $display("FAIL sat_count sel=%0d: got %0d expected 15", s, v); end
    end
  endtask

  task automatic test_clear_argmax();
    logic [CW-1:0] v;
    int cyc, bad;
    do_clear(1'b0);
    for (int i = 0; i < 5; i++) strobe(N'($urandom), i == 4);
    tick();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL argmax_busy: got %0b expected 1", bus.busy); end
    do_clear(1'b0);
    bad = 0;
    for (int i = 0; i < N + 3; i++) begin
      if (bus.winner_valid !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL clear_argmax_valid: got %0d high cycles expected 0", bad); end
    for (int s = 0; s < N; s++) begin
      read_count(s, v);
      checks++; if (v !== '0) begin failures++; $display("FAIL clear_argmax_count sel=%0d: got %0d expected 0", s, v); end
    end
    for (int i = 0; i < 3; i++) strobe(3'b100, i == 2);
    wait_winner(cyc);
    checks++; if (bus.winner !== 2'd2 || bus.winner_count !== 4'd3) begin failures++; $display("FAIL rerun_winner: got %0d/%0d expected 2/3", bus.winner, bus.winner_count); end
  endtask

  task automatic test_clear_coincident();
    logic [CW-1:0] v;
    int cyc;
    do_clear(1'b1);
    strobe(3'b111, 1'b0);
    strobe(3'b111, 1'b0);
    do_clear(1'b1);
    strobe(3'b001, 1'b1);
    wait_winner(cyc);
    checks++; if (bus.winner !== '0 || bus.winner_count !== 4'd1) begin failures++; $display("FAIL coincident_winner: got %0d/%0d expected 0/1", bus.winner, bus.winner_count); end
    read_count(1, v);
    checks++; if (v !== '0) begin failures++; $display("FAIL coincident_count1: got %0d expected 0", v); end
  endtask

  task automatic test_random();
    logic [CW-1:0] v;
    int cyc, len, w;
    for (int r = 0; r < 8; r++) begin
      do_clear(1'($urandom));
      len = int'($urandom_range(40, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(4, 0) == 0) tick();
        strobe(N'($urandom), i == len - 1);
      end
      wait_winner(cyc);
      w = mdl_winner();
      checks++; if (cyc != N + 1) begin failures++; $display("FAIL rand_latency run=%0d: got %0d expected %0d", r, cyc, N + 1); end
      checks++; if (bus.winner !== IW'(w) || bus.winner_count !== CW'(exp_cnt[w])) begin failures++; $display("FAIL rand_winner run=%0d: got %0d/%0d expected %0d/%0d", r, bus.winner, bus.winner_count, w, exp_cnt[w]); end
      checks++; if (bus.no_spikes !== (exp_cnt[w] == 0)) begin failures++; $display("FAIL rand_no_spikes run=%0d: got %0b expected %0b", r, bus.no_spikes, exp_cnt[w] == 0); end
      for (int s = 0; s < (1 << IW); s++) begin
        read_count(s, v);
        checks++;
        if (s < N) begin
          if (v !== CW'(exp_cnt[s])) begin failures++; $display("FAIL rand_readback run=%0d sel=%0d: got %0d expected %0d", r, s, v, exp_cnt[s]); end
        end else begin
          if (v !== '0) begin failures++; $display("FAIL rand_readback_oor run=%0d sel=%0d: got %0d expected 0", r, s, v); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [CW-1:0] v;
    int cyc;
    do_clear(1'b0);
    for (int i = 0; i < 2; i++) strobe(3'b100, i == 1);
    wait_winner(cyc);
    do_clear(1'b0);
    bus.count_sel = 2'd2;
    for (int i = 0; i < 3; i++) strobe(3'b100, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    mdl_reset();
    checks++; if (bus.busy !== 1'b0 || bus.winner_valid !== 1'b0 || bus.no_spikes !== 1'b0) begin failures++; $display("FAIL arst_flags: busy=%0b valid=%0b no_spikes=%0b expected 0/0/0", bus.busy, bus.winner_valid, bus.no_spikes); end
    checks++; if (bus.count_rdata !== '0) begin failures++; $display("FAIL arst_count_rdata: got %0d expected 0", bus.count_rdata); end
    checks++; if (bus.winner !== '0 || bus.winner_count !== '0) begin failures++; $display("FAIL arst_winner: got %0d/%0d expected 0/0", bus.winner, bus.winner_count); end
    tick();
    rst = 1'b0;
    tick();
    strobe(3'b111, 1'b0);
    read_count(2, v);
    checks++; if (v !== '0) begin failures++; $display("FAIL arst_idle_count: got %0d expected 0", v); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_idle_busy: got %0b expected 0", bus.busy); end
  endtask

  initial begin
    bus.clear        = 1'b0;
    bus.spikes_valid = 1'b0;
    bus.spikes       = '0;
    bus.last         = 1'b0;
    bus.count_sel    = '0;
    mdl_reset();
    test_reset();
    test_basic();
    test_tie();
    test_no_spikes();
    test_saturation();
    test_clear_argmax();
    test_clear_coincident();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snn_output_spike_counter.md
# snn_output_spike_counter

Downstream consumer of the SNN core's output layer. It accumulates per-neuron output spike counts over one simulation run (one strobe per timestep), then runs a sequential argmax to produce a classification winner. Counts and the winner are exposed to the AXI config-register block for software readback.

## Interface
- `NUM_OUTPUTS`, default 2: number of output-layer neurons (last entry of `NUM_HIDDEN_LAYER_NEURONS`); must be ≥ 1.
- `COUNT_WIDTH`, default 9: width of each spike counter; `MAX_TIMESTEPS_BITS + 1` holds a full 2^`MAX_TIMESTEPS_BITS` run without saturating.
- `IDX_WIDTH`, default max(1, clog2(`NUM_OUTPUTS`)): width of neuron index buses.

Ports:
- `clk`  in  1  the single clock for the block.
- `rst`  in  1  reset, asynchronous and active-high.
- `clear`  in  1  synchronous start: zeroes the counters and enters COUNT.
- `spikes_valid`  in  1  one-cycle strobe; `spikes` holds one timestep's outputs.
- `spikes`  in  `NUM_OUTPUTS`  output-layer spike vector; bit n is neuron n.
- `last`  in  1  qualifies `spikes_valid`; marks the final timestep of the run.
- `count_sel`  in  `IDX_WIDTH`  readback neuron select.
- `count_rdata`  out  `COUNT_WIDTH`  registered count of neuron `count_sel`.
- `winner`  out  `IDX_WIDTH`  index of the neuron with the highest count.
- `winner_count`  out  `COUNT_WIDTH`  count of `winner`.
- `winner_valid`  out  1  high in DONE.
- `no_spikes`  out  1  high in DONE when every count is 0.
- `busy`  out  1  high in COUNT and ARGMAX.

## Operation
- States: IDLE, COUNT, ARGMAX, DONE. Reset enters IDLE.
- IDLE: `spikes_valid` is ignored. `clear` goes to COUNT.
- COUNT: on each `spikes_valid`, every counter n whose `spikes[n]`=1 increments by 1.
  - Counters saturate at 2^`COUNT_WIDTH`−1 and never wrap.
  - `spikes_valid` & `last`: the timestep is counted, then the FSM goes to ARGMAX on the next cycle.
- ARGMAX: scans one neuron per cycle with index i = 0..`NUM_OUTPUTS`−1.
  - Running best starts at neuron 0 with its count.
  - Neuron i replaces best only if its count is strictly greater. On a tie, the lowest index wins.
  - After index `NUM_OUTPUTS`−1 is scanned, latch `winner` and `winner_count`, set `no_spikes` = (best count == 0), and go to DONE.
  - `spikes_valid` is ignored; counters are frozen.
- DONE: outputs hold. `spikes_valid` is ignored. `clear` goes to COUNT.
- `clear` has priority in every state, including mid-COUNT and mid-ARGMAX:
  - zeroes all counters;
  - drops `winner_valid` and `no_spikes`;
  - goes to COUNT.
  - If `clear` and `spikes_valid` assert in the same cycle, the spikes are discarded.
- Readback: `count_rdata` ← counter[`count_sel`] every cycle in all states. If `count_sel` ≥ `NUM_OUTPUTS`, it reads 0.

## Timing
- Reset values:
  - FSM = IDLE;
  - all counters, `count_rdata`, `winner`, `winner_count` = 0;
  - `winner_valid`, `no_spikes`, `busy` = 0.
- Counter update: a count sampled with `spikes_valid` at edge k is visible in `count_rdata` at edge k+1. That is 1-cycle read latency after `count_sel` is stable, plus 1 cycle from the spike.
- Last timestep at edge k:
  - ARGMAX occupies edges k+1 … k+`NUM_OUTPUTS`;
  - `winner_valid` rises after edge k+`NUM_OUTPUTS`+1.
- `busy` is registered: high the cycle after `clear` is sampled, low in the same cycle `winner_valid` rises.
- `clear` at edge k: counters read 0 in `count_rdata` after edge k+1. `spikes_valid` is accepted from edge k+1.
- `rst` asserted at any time asynchronously forces all reset values. There is no partial-run retention.

## Test plan
- Basic count, `NUM_OUTPUTS`=2:
  - stimulus: `clear`, then 10 strobes of `spikes`=2'b10 and 4 of 2'b01, last strobe with `last`;
  - required: counts 4 and 10; `winner`=1, `winner_count`=10, `winner_valid` exactly `NUM_OUTPUTS`+1 cycles after `last`.
- Tie, `NUM_OUTPUTS`=3:
  - stimulus: 5 strobes of 3'b110, `last`;
  - required: `winner`=1 (lowest index among the tied neurons); `no_spikes`=0.
- No spikes:
  - stimulus: 256 strobes of `spikes`=0, `last` on the final one;
  - required: `winner`=0, `winner_count`=0, `no_spikes`=1.
- Saturation, `COUNT_WIDTH`=4:
  - stimulus: 20 strobes of all-ones, `last`;
  - required: every count = 15, no wrap; `winner`=0.
- Mid-run `clear` and ignored strobes:
  - stimulus: `clear` during ARGMAX;
  - required: `winner_valid` stays 0, counters read 0, next run counts from 0.
  - stimulus: strobes in IDLE or DONE;
  - required: counts unchanged.
  - stimulus: `clear` coincident with `spikes_valid`;
  - required: that timestep is not counted.
- Readback and reset:
  - stimulus: sweep `count_sel` over 0..2^`IDX_WIDTH`−1 in DONE;
  - required: correct counts, 0 for out-of-range indices.
  - stimulus: assert `rst` mid-COUNT between clock edges;
  - required: all outputs 0 immediately, FSM in IDLE.
